rotenc_qdec: RTL and testbench

ROTENC_QDEC -- requirements
Module: rotenc_qdec

---
 rtl/rotenc_qdec.sv | 136 +++++++++++++
 tb/tb_rotenc_qdec.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rotenc_qdec.sv
// Quadrature encoder decoder: synchronizes and debounces A/B, decodes x1/x2/x4 steps
// into an up/down position counter with sticky illegal-transition flag.
module rotenc_qdec #(
  parameter int CNT_W    = 16,
  parameter int FILT_LEN = 4,
  parameter int SAT      = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             dir,
  output logic             step,
  output logic             err
);

  localparam int FC_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int ST_W = $clog2(FILT_LEN + 4);
  localparam logic [FC_W-1:0]  FC_MAX  = FC_W'(FILT_LEN - 1);
  localparam logic [ST_W-1:0]  ST_END  = ST_W'(FILT_LEN + 3);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [1:0]       MODE_X1 = 2'b00;
  localparam logic [1:0]       MODE_X2 = 2'b01;

  // Bit 1 carries channel A, bit 0 channel B throughout.
  logic [1:0]       s1_q, s1_d, s2_q, s2_d, f_q, f_d, prev_q, prev_d;
  logic [FC_W-1:0]  fc_q [2];
  logic [FC_W-1:0]  fc_d [2];
  logic [ST_W-1:0]  st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d, step_q, step_d, err_q, err_d;

  logic [1:0] chg;
  logic       run, illegal, step_req, step_up;

  always_comb begin
    s1_d = {a, b};
    s2_d = s1_q;
    f_d  = f_q;
    for (int i = 0; i < 2; i++) begin
      fc_d[i] = fc_q[i];
      if (s2_q[i] == f_q[i]) begin
        fc_d[i] = '0;
      end else if (fc_q[i] == FC_MAX) begin
        f_d[i]  = s2_q[i];
        fc_d[i] = '0;
      end else begin
        fc_d[i] = fc_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    chg      = prev_q ^ f_q;
    run      = (st_q == ST_END);
    illegal  = (chg == 2'b11);
    step_req = 1'b0;
    step_up  = 1'b0;
    if (mode == MODE_X1) begin
      step_req = (chg == 2'b10) && f_q[1];
      step_up  = f_q[0];
    end else if (mode == MODE_X2) begin
      step_req = (chg == 2'b10);
      step_up  = (f_q[1] == f_q[0]);
    end else begin
      step_req = (chg == 2'b10) || (chg == 2'b01);
      step_up  = prev_q[1] ^ f_q[0];
    end
  end

  always_comb begin
    prev_d = f_q;
    st_d   = run ? st_q : st_q + 1'b1;
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    err_d  = err_q;
    step_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
      err_d = 1'b0;
    end else if (run) begin
      if (illegal) begin
        err_d = 1'b1;
      end else if (step_req) begin
        dir_d = step_up;
        // In saturating mode the end stops still record direction but never pulse.
        if (step_up) begin
          if (!(SAT != 0 && cnt_q == CNT_MAX)) begin
            cnt_d  = cnt_q + 1'b1;
            step_d = 1'b1;
          end
        end else begin
          if (!(SAT != 0 && cnt_q == '0)) begin
            cnt_d  = cnt_q - 1'b1;
            step_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      f_q    <= '0;
      prev_q <= '0;
      st_q   <= '0;
      cnt_q  <= '0;
      dir_q  <= 1'b0;
      step_q <= 1'b0;
      err_q  <= 1'b0;
      for (int i = 0; i < 2; i++) fc_q[i] <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      f_q    <= f_d;
      prev_q <= prev_d;
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      step_q <= step_d;
      err_q  <= err_d;
      for (int i = 0; i < 2; i++) fc_q[i] <= fc_d[i];
    end
  end

  assign cnt  = cnt_q;
  assign dir  = dir_q;
  assign step = step_q;
  assign err  = err_q;

endmodule

// File: tb/tb_rotenc_qdec.sv
// Scoreboard bench for rotenc_qdec: expected steps (count, direction, arrival cycle)
// are queued when pins change and matched against each step pulse.
module tb_rotenc_qdec;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a = 1'b0, b = 1'b0, clr = 1'b0;
  logic [1:0]  mode = 2'b10;
  logic [15:0] cnt, cnt_s;
  logic        dir, step, err, dir_s, step_s, err_s;

  always #5 clk = ~clk;

  rotenc_qdec #(.CNT_W(16), .FILT_LEN(4), .SAT(0)) u_dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .mode(mode), .clr(clr),
    .cnt(cnt), .dir(dir), .step(step), .err(err)
  );

  rotenc_qdec #(.CNT_W(16), .FILT_LEN(4), .SAT(1)) u_sat (
    .clk(clk), .rst(rst), .a(a), .b(b), .mode(mode), .clr(clr),
    .cnt(cnt_s), .dir(dir_s), .step(step_s), .err(err_s)
  );

  typedef struct {
    logic [15:0] cnt;
    logic        dir;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_cnt = '0;
  int          checks = 0, failures = 0;
  int          cyc = 0, dut_steps = 0, sat_steps = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Every step pulse of the wrapping instance must match the oldest expectation.
  always @(negedge clk) begin
    if (step) begin
      exp_t e;
      dut_steps++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_step cnt=%0h dir=%0b cyc=%0d required=no step", cnt, dir, cyc);
      end else begin
        e = sb.pop_front();
        if (cnt !== e.cnt || dir !== e.dir || cyc !== e.cyc) begin
          failures++;
          $display("FAIL sb_step cnt=%0h dir=%0b cyc=%0d required cnt=%0h dir=%0b cyc=%0d",
                   cnt, dir, cyc, e.cnt, e.dir, e.cyc);
        end
      end
    end
    if (step_s) sat_steps++;
  end

  // Drive new pin levels; a non-zero delta predicts a step 7 negedges later (E0+6).
  task automatic apply(input logic [1:0] ab, input int delta, input int hold);
    exp_t e;
    @(negedge clk);
    a = ab[1];
    b = ab[0];
    if (delta != 0) begin
      m_cnt = m_cnt + 16'(delta);
      e.cnt = m_cnt;
      e.dir = (delta > 0);
      e.cyc = cyc + 7;
      sb.push_back(e);
    end
    repeat (hold - 1) @(negedge clk);
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m_cnt = '0;
    checks++;
    if (cnt !== 16'h0 || err !== 1'b0) begin
      failures++;
      $display("FAIL clr cnt=%0h err=%0b required cnt=0 err=0", cnt, err);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #11;
    checks++;
    if (cnt !== 16'h0 || dir !== 1'b0 || step !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs cnt=%0h dir=%0b step=%0b err=%0b required all 0", cnt, dir, step, err);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (cnt !== 16'h0 || err !== 1'b0 || dut_steps !== 0) begin
      failures++;
      $display("FAIL startup_quiet cnt=%0h err=%0b steps=%0d required 0/0/0", cnt, err, dut_steps);
    end
  endtask

  task automatic test_x4_forward();
    int s0;
    s0 = dut_steps;
    mode = 2'b10;
    apply(2'b01, 1, 20);
    apply(2'b11, 1, 20);
    apply(2'b10, 1, 20);
    apply(2'b00, 1, 20);
    checks++;
    if (cnt !== 16'd4 || dir !== 1'b1 || dut_steps - s0 !== 4 || sb.size() != 0) begin
      failures++;
      $display("FAIL x4_forward cnt=%0h dir=%0b steps=%0d pending=%0d required 4/1/4/0",
               cnt, dir, dut_steps - s0, sb.size());
    end
  endtask

  task automatic test_wrap_sat();
    int s0;
    do_clr();
    s0 = sat_steps;
    apply(2'b10, -1, 20);
    checks++;
    if (cnt !== 16'hFFFF || dir !== 1'b0) begin
      failures++;
      $display("FAIL wrap_down cnt=%0h dir=%0b required cnt=ffff dir=0", cnt, dir);
    end
    checks++;
    if (cnt_s !== 16'h0 || dir_s !== 1'b0 || sat_steps !== s0) begin
      failures++;
      $display("FAIL sat_floor cnt=%0h dir=%0b steps=%0d required cnt=0 dir=0 steps=%0d",
               cnt_s, dir_s, sat_steps, s0);
    end
    apply(2'b00, 1, 20);
    checks++;
    if (cnt !== 16'h0 || dir !== 1'b1) begin
      failures++;
      $display("FAIL wrap_up cnt=%0h dir=%0b required cnt=0 dir=1", cnt, dir);
    end
    do_clr();
  endtask

  task automatic test_glitch();
    int s0;
    apply(2'b01, 1, 20);
    s0 = dut_steps;
    apply(2'b11, 0, 3);
    apply(2'b01, 0, 20);
    checks++;
    if (dut_steps !== s0 || cnt !== m_cnt) begin
      failures++;
      $display("FAIL glitch_3clk cnt=%0h steps=%0d required cnt=%0h steps=%0d", cnt, dut_steps, m_cnt, s0);
    end
    apply(2'b11, 1, 5);
    apply(2'b01, -1, 20);
    checks++;
    if (dut_steps !== s0 + 2 || cnt !== 16'd1 || dir !== 1'b0) begin
      failures++;
      $display("FAIL pulse_5clk cnt=%0h dir=%0b steps=%0d required cnt=1 dir=0 steps=%0d",
               cnt, dir, dut_steps, s0 + 2);
    end
  endtask

  task automatic test_illegal();
    apply(2'b10, 0, 20);
    checks++;
    if (err !== 1'b1 || cnt !== 16'd1 || dir !== 1'b0) begin
      failures++;
      $display("FAIL illegal err=%0b cnt=%0h dir=%0b required err=1 cnt=1 dir=0", err, cnt, dir);
    end
    do_clr();
  endtask

  task automatic test_modes();
    logic [1:0]  mtab [3];
    int          dtab [3][4];
    logic [1:0]  seq  [4];
    logic [15:0] ftab [3];
    mtab = '{2'b00, 2'b01, 2'b10};
    dtab = '{'{0, 1, 0, 0}, '{0, 1, 0, 1}, '{1, 1, 1, 1}};
    seq  = '{2'b01, 2'b11, 2'b10, 2'b00};
    ftab = '{16'd1, 16'd2, 16'd4};
    apply(2'b00, 1, 20);
    do_clr();
    for (int m = 0; m < 3; m++) begin
      @(negedge clk);
      mode = mtab[m];
      for (int k = 0; k < 4; k++) apply(seq[k], dtab[m][k], 20);
      checks++;
      if (cnt !== ftab[m] || sb.size() != 0) begin
        failures++;
        $display("FAIL mode_%0d cnt=%0h pending=%0d required cnt=%0h pending=0", m, cnt, sb.size(), ftab[m]);
      end
      do_clr();
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] seq [7];
    seq = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10};
    mode = 2'b10;
    for (int k = 0; k < 7; k++) apply(seq[k], 1, 6);
    repeat (20) @(negedge clk);
    checks++;
    if (cnt !== 16'd7 || dir !== 1'b1 || sb.size() != 0) begin
      failures++;
      $display("FAIL back_to_back cnt=%0h dir=%0b pending=%0d required 7/1/0", cnt, dir, sb.size());
    end
  endtask

  task automatic test_async_reset();
    int s0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    a = 1'b1;
    b = 1'b1;
    #1;
    checks++;
    if (cnt !== 16'h0 || step !== 1'b0 || err !== 1'b0 || dir !== 1'b0) begin
      failures++;
      $display("FAIL async_reset cnt=%0h step=%0b err=%0b dir=%0b required all 0", cnt, step, err, dir);
    end
    sb.delete();
    m_cnt = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    s0 = dut_steps;
    repeat (30) @(negedge clk);
    checks++;
    if (cnt !== 16'h0 || err !== 1'b0 || dut_steps !== s0) begin
      failures++;
      $display("FAIL post_reset_11 cnt=%0h err=%0b steps=%0d required 0/0/%0d", cnt, err, dut_steps, s0);
    end
  endtask

  initial begin
    test_reset();
    test_x4_forward();
    test_wrap_sat();
    test_glitch();
    test_illegal();
    test_modes();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
